// File: rtl/multi_dataflow_job_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_dataflow_job_arbiter_pkg
// Description : Shared types and defaults for the multi_dataflow job arbiter
//               and its round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_dataflow_job_arbiter_pkg;

    localparam int ARB_N_REQ   = 4;
    localparam int ARB_N_WORDS = 7;
    localparam int ARB_DW      = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_START   = 2'd1,
        ARB_RUN     = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    // Descriptor layout for the default configuration: word 0 = input address,
    // word 1 = output address, word 2 = count limit, words 3..6 = coefficients.
    typedef logic [ARB_N_WORDS-1:0][ARB_DW-1:0] job_desc_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_dataflow_job_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : multi_dataflow_rr_arbiter
// Description : Combinational round-robin search. Starting at i_ptr and
//               wrapping modulo N_REQ, returns the first set valid bit as a
//               one-hot grant and as an index.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_dataflow_rr_arbiter
    import multi_dataflow_job_arbiter_pkg::*;
#(
    parameter  int N_REQ   = ARB_N_REQ,
    localparam int c_idx_w = arb_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0]   i_valid,
    input  logic [c_idx_w-1:0] i_ptr,
    output logic [N_REQ-1:0]   o_grant,
    output logic [c_idx_w-1:0] o_idx,
    output logic               o_any
);

    // One extra bit so ptr + offset never wraps before the modulo fold.
    logic [c_idx_w:0]   w_sum;
    logic [c_idx_w-1:0] w_cand;

    // Walk candidates ptr, ptr+1, ... and keep the first valid one.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, i_ptr} + (c_idx_w+1)'(i);
            if (w_sum >= (c_idx_w+1)'(N_REQ)) begin
                w_sum = w_sum - (c_idx_w+1)'(N_REQ);
            end
            w_cand = w_sum[c_idx_w-1:0];
            if (!o_any && i_valid[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_dataflow_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : multi_dataflow_job_arbiter
// Description : Shares one multi_dataflow HWPE between N_REQ requesters.
//               Round-robin grant, descriptor latch, start pulse, completion
//               event back to the owner, and a watchdog that aborts hung jobs.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_dataflow_job_arbiter
    import multi_dataflow_job_arbiter_pkg::*;
#(
    parameter  int N_REQ   = ARB_N_REQ,
    parameter  int N_WORDS = ARB_N_WORDS,
    parameter  int DW      = ARB_DW,
    parameter  int TO_W    = 16,
    localparam int c_idx_w  = arb_idx_w(N_REQ),
    localparam int c_desc_w = N_WORDS * DW
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [N_REQ*c_desc_w-1:0] req_desc_i,
    output logic [c_desc_w-1:0]       job_desc_o,
    output logic                      job_start_o,
    input  logic                      job_done_i,
    output logic                      engine_clear_o,
    output logic [N_REQ-1:0]          done_evt_o,
    output logic                      done_err_o,
    output logic                      busy_o,
    output logic [c_idx_w-1:0]        owner_o,
    input  logic [TO_W-1:0]           timeout_limit_i,
    output logic                      timeout_o
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_idx_w-1:0]  r_rr_ptr;
    logic [c_idx_w-1:0]  r_owner;
    logic [c_desc_w-1:0] r_desc;
    logic [TO_W-1:0]     r_count;
    logic                r_timeout;
    logic                r_err;

    logic [N_REQ-1:0]    w_arb_grant;
    logic [c_idx_w-1:0]  w_arb_idx;
    logic                w_arb_any;
    logic                w_wd_hit;
    logic [c_idx_w-1:0]  w_ptr_nxt;

    logic                w_take;
    logic                w_cnt_clr;
    logic                w_cnt_inc;
    logic                w_done_ok;
    logic                w_abort;
    logic                w_release;

    multi_dataflow_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .i_valid (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // A zero limit disables the watchdog entirely.
    assign w_wd_hit  = (timeout_limit_i != '0) && (r_count == (timeout_limit_i - TO_W'(1)));
    assign w_ptr_nxt = (r_owner == c_idx_w'(N_REQ-1)) ? '0 : (r_owner + c_idx_w'(1));

    assign job_desc_o = r_desc;
    assign owner_o    = r_owner;
    assign timeout_o  = r_timeout;
    assign busy_o     = (r_state != ARB_IDLE);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake, pulses and datapath strobes; clear_i suppresses all of them.
    always_comb begin
        w_state_nxt    = r_state;
        req_ready_o    = '0;
        job_start_o    = 1'b0;
        engine_clear_o = 1'b0;
        done_evt_o     = '0;
        done_err_o     = 1'b0;
        w_take         = 1'b0;
        w_cnt_clr      = 1'b0;
        w_cnt_inc      = 1'b0;
        w_done_ok      = 1'b0;
        w_abort        = 1'b0;
        w_release      = 1'b0;
        if (clear_i) begin
            w_state_nxt = ARB_IDLE;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_arb_any) begin
                        req_ready_o = w_arb_grant;
                        w_take      = 1'b1;
                        w_state_nxt = ARB_START;
                    end
                end
                ARB_START: begin
                    job_start_o = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ARB_RUN;
                end
                ARB_RUN: begin
                    // A done on the expiry cycle counts as a clean completion.
                    if (job_done_i) begin
                        w_done_ok   = 1'b1;
                        w_state_nxt = ARB_RELEASE;
                    end else if (w_wd_hit) begin
                        engine_clear_o = 1'b1;
                        w_abort        = 1'b1;
                        w_state_nxt    = ARB_RELEASE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                ARB_RELEASE: begin
                    done_evt_o[r_owner] = 1'b1;
                    done_err_o          = r_err;
                    w_release           = 1'b1;
                    w_state_nxt         = ARB_IDLE;
                end
                default: begin
                    w_state_nxt = ARB_IDLE;
                end
            endcase
        end
    end

    // Descriptor latch, owner, round-robin pointer, watchdog counter and flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_desc    <= '0;
            r_count   <= '0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
        end else if (clear_i) begin
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_desc    <= '0;
            r_count   <= '0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_take) begin
                r_desc  <= req_desc_i[w_arb_idx*c_desc_w +: c_desc_w];
                r_owner <= w_arb_idx;
            end
            if (w_cnt_clr) begin
                r_count <= '0;
            end else if (w_cnt_inc && (r_count != '1)) begin
                r_count <= r_count + TO_W'(1);
            end
            if (w_done_ok) begin
                r_err <= 1'b0;
            end
            if (w_abort) begin
                r_err     <= 1'b1;
                r_timeout <= 1'b1;
            end
            if (w_release) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_dataflow_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_dataflow_job_arbiter
// Description : Directed self-checking bench for multi_dataflow_job_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_dataflow_job_arbiter;

    localparam int N_REQ   = 4;
    localparam int N_WORDS = 7;
    localparam int DW      = 32;
    localparam int TO_W    = 16;
    localparam int DESC_W  = N_WORDS * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                 rst_ni;
    logic                                 clear_i;
    logic [N_REQ-1:0]                     req_valid_i;
    logic [N_REQ-1:0]                     req_ready_o;
    logic [N_REQ-1:0][N_WORDS-1:0][DW-1:0] req_desc;
    logic [DESC_W-1:0]                    job_desc_o;
    logic                                 job_start_o;
    logic                                 job_done_i;
    logic                                 engine_clear_o;
    logic [N_REQ-1:0]                     done_evt_o;
    logic                                 done_err_o;
    logic                                 busy_o;
    logic [1:0]                           owner_o;
    logic [TO_W-1:0]                      timeout_limit_i;
    logic                                 timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    multi_dataflow_job_arbiter #(
        .N_REQ   (N_REQ),
        .N_WORDS (N_WORDS),
        .DW      (DW),
        .TO_W    (TO_W)
    ) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .clear_i         (clear_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_desc_i      (req_desc),
        .job_desc_o      (job_desc_o),
        .job_start_o     (job_start_o),
        .job_done_i      (job_done_i),
        .engine_clear_o  (engine_clear_o),
        .done_evt_o      (done_evt_o),
        .done_err_o      (done_err_o),
        .busy_o          (busy_o),
        .owner_o         (owner_o),
        .timeout_limit_i (timeout_limit_i),
        .timeout_o       (timeout_o)
    );

    task automatic check(input string tag, input logic [DESC_W-1:0] obs, input logic [DESC_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_REQ-1:0] oh(input int g);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // Entered in IDLE with req_valid_i already driven; leaves in IDLE one
    // cycle after the completion event. done_at / abort_at count cycles after
    // the start pulse (-1 = never).
    task automatic do_job(input int exp_g, input int done_at, input int abort_at, input logic exp_err);
        int last;
        logic [DESC_W-1:0] exp_desc;
        exp_desc = req_desc[exp_g];
        #1;
        check("grant_ready", req_ready_o, oh(exp_g));
        check("idle_busy", busy_o, 0);
        tick();
        check("start_pulse", job_start_o, 1);
        check("owner", owner_o, exp_g);
        check("desc", job_desc_o, exp_desc);
        check("start_busy", busy_o, 1);
        check("start_ready", req_ready_o, 0);
        last = (done_at > 0) ? done_at : abort_at;
        for (int k = 1; k <= last; k++) begin
            tick();
            job_done_i = (k == done_at);
            #1;
            check("engine_clear", engine_clear_o, (k == abort_at) && (k != done_at));
        end
        tick();
        job_done_i = 1'b0;
        #1;
        check("done_evt", done_evt_o, oh(exp_g));
        check("done_err", done_err_o, exp_err);
        check("release_start", job_start_o, 0);
        tick();
        check("post_evt", done_evt_o, 0);
        check("post_busy", busy_o, 0);
    endtask

    initial begin
        rst_ni          = 1'b0;
        clear_i         = 1'b0;
        req_valid_i     = '0;
        job_done_i      = 1'b0;
        timeout_limit_i = '0;
        for (int r = 0; r < N_REQ; r++) begin
            for (int w = 0; w < N_WORDS; w++) begin
                req_desc[r][w] = 32'hA000_0000 | (r << 8) | w;
            end
        end
        req_desc[2][0] = 32'h0000_1000;
        req_desc[2][1] = 32'h0000_2000;
        req_desc[2][2] = 32'd16;
        req_desc[2][3] = 32'h11;
        req_desc[2][4] = 32'h22;
        req_desc[2][5] = 32'h33;
        req_desc[2][6] = 32'h44;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy_o, 0);
        check("rst_owner", owner_o, 0);
        check("rst_desc", job_desc_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_start", job_start_o, 0);
        check("rst_evt", done_evt_o, 0);
        check("rst_eclr", engine_clear_o, 0);
        check("rst_ready", req_ready_o, 0);
        rst_ni = 1'b1;
        tick();

        // Single job from requester 2, done 20 cycles after start
        timeout_limit_i = 16'd100;
        req_valid_i     = 4'b0100;
        do_job(2, 20, -1, 1'b0);
        // Pointer now at 3
        req_valid_i = 4'b1111;
        #1;
        check("rr_ptr_3", req_ready_o, 4'b1000);
        req_valid_i = 4'b0000;

        // Watchdog abort: search 3,0,1 -> requester 1
        timeout_limit_i = 16'd10;
        req_valid_i     = 4'b0010;
        do_job(1, -1, 10, 1'b1);
        req_valid_i = 4'b0000;
        check("timeout_set", timeout_o, 1);

        // Tie on expiry cycle: search 2,3,0 -> requester 0, done wins
        req_valid_i = 4'b0001;
        do_job(0, 10, 10, 1'b0);
        req_valid_i = 4'b0000;
        check("timeout_sticky", timeout_o, 1);

        // Spurious done in IDLE
        job_done_i = 1'b1;
        tick();
        job_done_i = 1'b0;
        #1;
        check("spur_idle_evt", done_evt_o, 0);
        check("spur_idle_busy", busy_o, 0);

        // Spurious done in START, then clear in RUN (pointer at 1 -> grant 2)
        req_valid_i = 4'b0100;
        #1;
        check("spur_ready", req_ready_o, 4'b0100);
        tick();
        req_valid_i = 4'b0000;
        job_done_i  = 1'b1;
        #1;
        check("spur_start", job_start_o, 1);
        tick();
        job_done_i = 1'b0;
        #1;
        check("spur_run_busy", busy_o, 1);
        check("spur_run_evt", done_evt_o, 0);
        tick();
        check("spur_run_evt2", done_evt_o, 0);
        check("spur_run_busy2", busy_o, 1);
        clear_i = 1'b1;
        #1;
        check("clr_eclr", engine_clear_o, 0);
        check("clr_evt", done_evt_o, 0);
        tick();
        clear_i = 1'b0;
        #1;
        check("clr_busy", busy_o, 0);
        check("clr_timeout", timeout_o, 0);
        check("clr_owner", owner_o, 0);
        check("clr_desc", job_desc_o, 0);
        check("clr_evt2", done_evt_o, 0);
        tick();
        check("clr_evt3", done_evt_o, 0);

        // Fairness: all valid, grants 0,1,2,3,0 starting from cleared pointer
        req_valid_i = 4'b1111;
        do_job(0, 5, -1, 1'b0);
        do_job(1, 5, -1, 1'b0);
        do_job(2, 5, -1, 1'b0);
        do_job(3, 5, -1, 1'b0);
        do_job(0, 5, -1, 1'b0);
        req_valid_i = 4'b0000;

        // Disabled watchdog, long job (pointer 1 -> requester 1)
        timeout_limit_i = 16'd0;
        req_valid_i     = 4'b0010;
        do_job(1, 70000, -1, 1'b0);
        req_valid_i = 4'b0000;
        check("long_timeout", timeout_o, 0);

        // Async reset mid-RUN (pointer 2 -> requester 2)
        timeout_limit_i = 16'd10;
        req_valid_i     = 4'b0100;
        #1;
        check("ar_ready", req_ready_o, 4'b0100);
        tick();
        req_valid_i = 4'b0000;
        tick();
        tick();
        tick();
        check("ar_busy_pre", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_busy", busy_o, 0);
        check("ar_desc", job_desc_o, 0);
        check("ar_owner", owner_o, 0);
        check("ar_start", job_start_o, 0);
        check("ar_evt", done_evt_o, 0);
        check("ar_err", done_err_o, 0);
        check("ar_eclr", engine_clear_o, 0);
        check("ar_timeout", timeout_o, 0);
        check("ar_ready0", req_ready_o, 0);
        job_done_i = 1'b1;
        tick();
        job_done_i = 1'b0;
        rst_ni     = 1'b1;
        tick();
        check("ar_post_evt", done_evt_o, 0);
        check("ar_post_busy", busy_o, 0);
        tick();
        check("ar_post_evt2", done_evt_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_dataflow_job_arbiter.md
Name: multi_dataflow_job_arbiter

Overview:
Shares one multi_dataflow HWPE between N_REQ requesters, such as cores or DMA-side job queues. Each requester submits a job descriptor (stream base addresses, output count limit, coefficients). The block arbitrates round-robin, latches the winner's descriptor, and pulses start into the HWPE control FSM. It then waits for done and returns a completion or error event to the owning requester. A watchdog aborts hung jobs.

Parameters:
N_REQ, 4, number of requesters (2..16)
N_WORDS, 7, 32-bit descriptor words per job (in addr, out addr, cnt limit, coeff0..3)
DW, 32, descriptor word width
TO_W, 16, watchdog counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous soft clear
req_valid_i  in  N_REQ  per-requester job valid
req_ready_o  out  N_REQ  per-requester accept (one-hot or zero)
req_desc_i  in  N_REQ*N_WORDS*DW  packed descriptors, requester r at slice r
job_desc_o  out  N_WORDS*DW  latched descriptor driven to HWPE register file
job_start_o  out  1  one-cycle start pulse to HWPE FSM
job_done_i  in  1  HWPE done pulse
engine_clear_o  out  1  one-cycle HWPE clear on watchdog abort
done_evt_o  out  N_REQ  one-cycle completion event to owner
done_err_o  out  1  qualifies done_evt_o: 1 means the job was aborted
busy_o  out  1  a job is granted or running
owner_o  out  clog2(N_REQ)  index of current or last owner
timeout_limit_i  in  TO_W  watchdog limit in cycles; 0 disables the watchdog
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (async) and clear_i (sync) both force the following:
  - state IDLE, rr_ptr=0, owner_o=0
  - job_desc_o=0, timeout_o=0, watchdog count=0
  - all pulses and ready/evt outputs = 0
- clear_i has priority over every transition in the same cycle.
- States: IDLE, START, RUN, RELEASE.
- IDLE:
  - Combinational round-robin search from rr_ptr upward, mod N_REQ, for the first set req_valid_i bit g.
  - req_ready_o = onehot(g) only in IDLE and only when some valid is set.
  - On handshake: latch slice g into job_desc_o, owner_o<=g, go to START.
  - busy_o=0 in IDLE, 1 in all other states.
- START: job_start_o=1 for exactly this cycle, count<=0, go to RUN. job_desc_o is stable from START until the next grant.
- RUN:
  - If job_done_i=1: go to RELEASE with err=0.
  - Else if timeout_limit_i!=0 and count==timeout_limit_i-1: engine_clear_o=1 this cycle, timeout_o<=1, go to RELEASE with err=1.
  - Else count++ (saturating).
  - job_done_i and watchdog expiry in the same cycle: done wins, err=0.
- RELEASE:
  - done_evt_o[owner]=1 and done_err_o=err for exactly this cycle.
  - rr_ptr<=(owner+1) mod N_REQ, go to IDLE.
- job_done_i outside RUN is ignored (no event, no state change).
- Latency:
  - grant to start pulse: 1 cycle.
  - job_done_i to done_evt_o: 1 cycle.
  - done_evt_o to next possible grant: 1 cycle (IDLE).
- A requester dropping req_valid_i before the handshake loses nothing; no grant is recorded.
- Descriptor content is not interpreted; it is width-exact pass-through.
- timeout_o stays set until clear_i or reset, and is not cleared by later successful jobs.
- An asynchronous reset mid-RUN abandons the job with no event.

Decomposition:
- multi_dataflow_package gains:
  - arb_state_t enum (ARB_IDLE, ARB_START, ARB_RUN, ARB_RELEASE)
  - ARB_N_REQ, ARB_N_WORDS defaults
  - job_desc_t as a packed array of N_WORDS x DW
- One sub-module, multi_dataflow_rr_arbiter: purely combinational, taking valid vector and rr_ptr and returning a one-hot grant and index. It is reusable by other HWPE wrappers.
- The FSM, descriptor register and watchdog stay in the top module.

Test Plan:
- Single job: req_valid_i=4'b0100, desc words 0x1000/0x2000/16..., done 20 cycles after start → req_ready_o=4'b0100 at cycle 0; job_start_o at cycle 1; job_desc_o equals slice 2; done_evt_o=4'b0100 with done_err_o=0 one cycle after done; rr_ptr=3.
- Fairness: all four valid continuously, done 5 cycles after each start → grant order 0,1,2,3,0; no requester granted twice before the others.
- Watchdog: timeout_limit_i=10, job_done_i never asserted → engine_clear_o pulse exactly 10 cycles after job_start_o; done_evt_o[owner]=1 with done_err_o=1; timeout_o stays 1 over the next successful job.
- Tie: job_done_i asserted on the watchdog expiry cycle → done_err_o=0 and engine_clear_o=0.
- Spurious done and clear: job_done_i pulsed in IDLE and in START → no event. clear_i in RUN → state IDLE, timeout_o=0, no done_evt_o, and the next grant starts from requester 0.
- Disabled watchdog and async reset: timeout_limit_i=0 with a 70000-cycle job → no abort and count saturates. rst_ni low mid-RUN → all outputs 0 immediately.
